// File: rtl/fadd_arb.sv
// Two-requester round-robin front end for one shared floating-point adder.
// Each accepted operation owns the adder until its result lands in that requester's result slot.
module fadd_arb #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_y,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_y,
    output logic [31:0] fa_x1,
    output logic [31:0] fa_x2,
    input  logic [31:0] fa_y,
    output logic        busy,
    output logic        dbg_state
);

    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ptr;    // requester favoured when both are eligible
    logic          owner;
    logic          elig0;
    logic          elig1;
    logic          accept;
    logic          winner;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and a result slot holds res_y stable until taken.
    always_comb begin
        elig0      = req0_valid && !res0_valid;
        elig1      = req1_valid && !res1_valid;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == S_IDLE) begin
            req0_ready = elig0 && (!elig1 || !ptr);
            req1_ready = elig1 && (!elig0 || ptr);
        end
        accept = req0_ready || req1_ready;
        winner = req1_ready;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res0_y     <= '0;
            res1_y     <= '0;
            fa_x1      <= '0;
            fa_x2      <= '0;
        end else begin
            if (res0_valid && res0_ready) res0_valid <= 1'b0;
            if (res1_valid && res1_ready) res1_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        fa_x1 <= winner ? req1_x1 : req0_x1;
                        fa_x2 <= winner ? req1_x2 : req0_x2;
                        owner <= winner;
                        ptr   <= !winner;
                        cnt   <= CW'(LAT);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // The owner's slot was empty at accept and nothing else can fill it.
                        if (owner) begin
                            res1_y     <= fa_y;
                            res1_valid <= 1'b1;
                        end else begin
                            res0_y     <= fa_y;
                            res0_valid <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_fadd_arb.sv
// Bench for fadd_arb: directed vector table plus hand-written arbitration, stall and reset sequences.
// A LAT-stage lookup adder stands in for the shared floating-point unit.
module tb_fadd_arb;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_x1 = '0, req0_x2 = '0, req1_x1 = '0, req1_x2 = '0;
    logic        res0_valid, res1_valid;
    logic        res0_ready = 1'b0, res1_ready = 1'b0;
    logic [31:0] res0_y, res1_y;
    logic [31:0] fa_x1, fa_x2, fa_y;
    logic        busy, dbg_state;

    fadd_arb #(.LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_y(res0_y),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_y(res1_y),
        .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // adder model: hand-computed sums, two register stages
    function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h40400000_BF800000: return 32'h40000000;
            64'h40000000_40000000: return 32'h40800000;
            64'h3F000000_3F000000: return 32'h3F800000;
            64'h3FC00000_40200000: return 32'h40800000;
            64'hC0000000_C0000000: return 32'hC0800000;
            default:               return 32'hDEAD0000 ^ a ^ b;
        endcase
    endfunction

    logic [31:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= fsum(fa_x1, fa_x2);
        p2 <= p1;
    end
    assign fa_y = p2;

    // scoreboard
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        res0_ready = 1'b0; res1_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic issue(input int p, input logic [31:0] x1, input logic [31:0] x2, output int acc);
        acc = -1;
        @(negedge clk);
        if (p == 0) begin req0_valid = 1'b1; req0_x1 = x1; req0_x2 = x2; end
        else        begin req1_valid = 1'b1; req1_x1 = x1; req1_x2 = x2; end
        for (int i = 0; i < 40; i++) begin
            #1;
            if (((p == 0) ? req0_ready : req1_ready) === 1'b1) begin
                acc = cyc + 1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chkb("accept_seen", acc >= 0, 1'b1);
    endtask

    task automatic wait_result(input int p, output int edge_no, output logic [31:0] y);
        edge_no = -1;
        y = 'x;
        for (int i = 0; i < 40; i++) begin
            if (((p == 0) ? res0_valid : res1_valid) === 1'b1) begin
                edge_no = cyc;
                y = (p == 0) ? res0_y : res1_y;
                break;
            end
            @(negedge clk);
        end
        chkb("result_seen", edge_no >= 0, 1'b1);
    endtask

    task automatic consume(input int p);
        @(negedge clk);
        if (p == 0) res0_ready = 1'b1; else res1_ready = 1'b1;
        @(negedge clk);
        res0_ready = 1'b0; res1_ready = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc, acc0, acc1, re;
        logic [31:0] y;
        logic seen;
        int ports[$];
        int edges[$];

        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000};
        vecs[1] = '{1, 32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[2] = '{0, 32'h40400000, 32'hBF800000, 32'h40000000};
        vecs[3] = '{1, 32'h3F000000, 32'h3F000000, 32'h3F800000};
        vecs[4] = '{0, 32'h3FC00000, 32'h40200000, 32'h40800000};
        vecs[5] = '{1, 32'hC0000000, 32'hC0000000, 32'hC0800000};

        // reset state
        @(negedge clk);
        #1;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_res0_valid", res0_valid, 1'b0);
        chkb("rst_res1_valid", res1_valid, 1'b0);
        chk("rst_fa_x1", fa_x1, 32'h0);
        chk("rst_fa_x2", fa_x2, 32'h0);
        chk("rst_res0_y", res0_y, 32'h0);
        chk("rst_res1_y", res1_y, 32'h0);
        do_reset();

        // table-driven single operations
        foreach (vecs[k]) begin
            issue(vecs[k].port, vecs[k].x1, vecs[k].x2, acc);
            chkb("busy_in_wait", busy, 1'b1);
            chk("fa_x1_loaded", fa_x1, vecs[k].x1);
            chk("fa_x2_loaded", fa_x2, vecs[k].x2);
            wait_result(vecs[k].port, re, y);
            chk("latency", 32'(re - acc), 32'(LAT + 1));
            chk("res_y", y, vecs[k].y);
            chkb("other_res_empty", (vecs[k].port == 0) ? res1_valid : res0_valid, 1'b0);
            chkb("busy_after", busy, 1'b0);
            consume(vecs[k].port);
            chkb("res_cleared", (vecs[k].port == 0) ? res0_valid : res1_valid, 1'b0);
        end

        // simultaneous requests after reset: requester 0 first
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_x1 = 32'h3F800000; req0_x2 = 32'h3F800000;
        req1_valid = 1'b1; req1_x1 = 32'h40400000; req1_x2 = 32'hBF800000;
        #1;
        chkb("sim_req0_ready", req0_ready, 1'b1);
        chkb("sim_req1_ready", req1_ready, 1'b0);
        acc0 = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        acc1 = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req1_ready === 1'b1) begin
                acc1 = cyc + 1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        chk("sim_req1_accept_gap", 32'(acc1 - acc0), 32'(LAT + 2));
        chkb("sim_res0_valid", res0_valid, 1'b1);
        chk("sim_res0_y", res0_y, 32'h40000000);
        wait_result(1, re, y);
        chk("sim_res1_latency", 32'(re - acc1), 32'(LAT + 1));
        chk("sim_res1_y", y, 32'h40000000);
        @(negedge clk);
        res0_ready = 1'b1; res1_ready = 1'b1;
        @(negedge clk);
        res0_ready = 1'b0; res1_ready = 1'b0;

        // fairness: both continuously valid, results consumed every cycle
        do_reset();
        res0_ready = 1'b1; res1_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_x1 = 32'h3F800000; req0_x2 = 32'h3F800000;
        req1_valid = 1'b1; req1_x1 = 32'h40400000; req1_x2 = 32'hBF800000;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready === 1'b1) begin ports.push_back(0); edges.push_back(cyc + 1); end
            if (req1_ready === 1'b1) begin ports.push_back(1); edges.push_back(cyc + 1); end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
        chkb("fair_accept_count", ports.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < ports.size(); i++) begin
            chk("fair_port", 32'(ports[i]), exp_q.pop_front());
            chk("fair_edge", 32'(edges[i] - edges[0]), 32'(i * (LAT + 2)));
        end
        repeat (6) @(negedge clk);
        res0_ready = 1'b0; res1_ready = 1'b0;

        // back-pressure on result slot 0
        do_reset();
        res1_ready = 1'b1;
        issue(0, 32'h3F800000, 32'h40000000, acc);
        wait_result(0, re, y);
        @(negedge clk);
        req0_valid = 1'b1; req0_x1 = 32'h40000000; req0_x2 = 32'h40000000;
        req1_valid = 1'b1; req1_x1 = 32'h3F000000; req1_x2 = 32'h3F000000;
        acc1 = -1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req0_ready !== 1'b0) seen = 1'b1;
            if (req1_ready === 1'b1 && acc1 < 0) acc1 = cyc + 1;
            @(negedge clk);
            if (acc1 >= 0) req1_valid = 1'b0;
        end
        chkb("bp_req0_blocked", seen, 1'b0);
        chkb("bp_req1_served", acc1 >= 0, 1'b1);
        chk("bp_res0_y_stable", res0_y, 32'h40400000);
        chkb("bp_idle", busy, 1'b0);
        res1_ready = 1'b0;
        res0_ready = 1'b1;
        #1;
        chkb("bp_consuming_still_full", req0_ready, 1'b0);
        @(negedge clk);
        res0_ready = 1'b0;
        #1;
        chkb("bp_res0_cleared", res0_valid, 1'b0);
        chkb("bp_req0_ready", req0_ready, 1'b1);
        acc0 = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        chkb("bp_req0_accepted", busy, 1'b1);
        wait_result(0, re, y);
        chk("bp_res0_latency", 32'(re - acc0), 32'(LAT + 1));
        chk("bp_res0_y", y, 32'h40800000);
        consume(0);

        // operand stability while the request inputs keep changing
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_x1 = 32'h3F800000; req0_x2 = 32'h40000000;
        #1;
        chkb("stab_ready", req0_ready, 1'b1);
        acc = cyc + 1;
        @(posedge clk);
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            chk("stab_fa_x1", fa_x1, 32'h3F800000);
            chk("stab_fa_x2", fa_x2, 32'h40000000);
            req0_x1 = $urandom_range(32'hFFFF_FFFF, 0);
            req0_x2 = $urandom_range(32'hFFFF_FFFF, 0);
        end
        req0_valid = 1'b0;
        chkb("stab_res0_valid", res0_valid, 1'b1);
        chk("stab_res0_y", res0_y, 32'h40400000);
        consume(0);

        // mid-operation reset
        do_reset();
        issue(1, 32'h40000000, 32'h40000000, acc);
        wait_result(1, re, y);
        issue(0, 32'h3F800000, 32'h40000000, acc);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chkb("mid_busy", busy, 1'b0);
        chk("mid_fa_x1", fa_x1, 32'h0);
        chk("mid_fa_x2", fa_x2, 32'h0);
        chkb("mid_res0_valid", res0_valid, 1'b0);
        chkb("mid_res1_valid", res1_valid, 1'b0);
        chk("mid_res1_y", res1_y, 32'h0);
        chk("mid_res0_y", res0_y, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res0_valid !== 1'b0 || res1_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chkb("mid_no_late_result", seen, 1'b0);

        // accept on the very first edge after reset release
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        req0_valid = 1'b1; req0_x1 = 32'h3F800000; req0_x2 = 32'h3F800000;
        #1;
        chkb("first_edge_ready", req0_ready, 1'b1);
        acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        chkb("first_edge_busy", busy, 1'b1);
        wait_result(0, re, y);
        chk("first_edge_latency", 32'(re - acc), 32'(LAT + 1));
        chk("first_edge_y", y, 32'h40000000);
        consume(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
